// File: rtl/ns_seq_src_pkg.sv
// Purpose : shared NS link field widths and the redundancy fold used by link ends.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
package ns_seq_src_pkg;

    // Default link field widths; link ends override them through parameters.
    localparam int NS_ADDRESS_SIZE = 6;
    localparam int NS_DATA_SIZE    = 32;
    localparam int NS_REDUN_SIZE   = 4;

    // Widest {src,dst,dat} concatenation the fold helper accepts. Callers
    // zero-extend into this width; the extra zero bits do not change the fold.
    localparam int NS_FOLD_IN_W    = 128;

    // One bit of the XOR-fold: bit j of the redundancy word is the parity of
    // every input bit whose position is congruent to j modulo the chunk size.
    // This equals XOR-ing rsz-bit chunks with a zero-padded top chunk.
    function automatic logic ns_fold_bit(input logic [NS_FOLD_IN_W-1:0] v,
                                         input int rsz,
                                         input int j);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NS_FOLD_IN_W; i++) begin
            if ((i % rsz) == j) begin
                b = b ^ (|(v & (NS_FOLD_IN_W'(1) << i)));
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/ns_seq_src_if.sv
// Purpose : one NS link channel (4-phase req/ack) carrying src/dst/dat/red.
// Latency : n/a (wiring only).
// Backpr. : receiver holds ack high until req drops; sender waits on ack.
// Ports   : req/src/dst/dat/red flow master->slave, ack flows slave->master.
interface ns_seq_src_if #(
    parameter int ASZ = ns_seq_src_pkg::NS_ADDRESS_SIZE,
    parameter int DSZ = ns_seq_src_pkg::NS_DATA_SIZE,
    parameter int RSZ = ns_seq_src_pkg::NS_REDUN_SIZE
) ();
    logic           req;
    logic           ack;
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;

    modport master (output req, src, dst, dat, red, input ack);
    modport slave  (input req, src, dst, dat, red, output ack);
endinterface

// File: rtl/ns_sync2.sv
// Purpose : 2-flop synchronizer for a single level signal into i_clk.
// Latency : 2 i_clk cycles from i_d change to o_q change.
// Backpr. : none; a pure level follower.
// Ports   : i_clk, i_rst_n (async active-low), i_d async input, o_q synced output.
module ns_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/ns_seq_src.sv
// Purpose : drives a deterministic message stream (dst sweep, counting data) on one NS send link.
// Latency : start edge to req high 2 cycles; 7 cycles per message with an immediately responding ack.
// Backpr. : each message waits for the full 4-phase ack; never raises req while the synced ack is high.
// Ports   : i_clk, reset (async active-low), i_start (rising edge launches a run),
//           snd0 link master, o_busy/o_done run status, o_cnt acknowledged messages.
module ns_seq_src
    import ns_seq_src_pkg::*;
#(
    parameter int ASZ      = NS_ADDRESS_SIZE,
    parameter int DSZ      = NS_DATA_SIZE,
    parameter int RSZ      = NS_REDUN_SIZE,
    parameter int MIN_ADDR = 0,
    parameter int MAX_ADDR = 55,
    parameter int REF_ADDR = 23,
    parameter int NUM_MSGS = 16
) (
    input  logic                i_clk,
    input  logic                reset,
    input  logic                i_start,
    ns_seq_src_if.master        snd0,
    output logic                o_busy,
    output logic                o_done,
    output logic [15:0]         o_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_REQ_HI = 3'd2,
        ST_REQ_LO = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [NS_FOLD_IN_W-1:0] RST_FOLD_IN =
        NS_FOLD_IN_W'({ASZ'(REF_ADDR), ASZ'(MIN_ADDR), DSZ'(0)});

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_start_q;
    logic                    r_req;
    logic [ASZ-1:0]          r_src;
    logic [ASZ-1:0]          r_dst;
    logic [DSZ-1:0]          r_dat;
    logic [RSZ-1:0]          r_red;
    logic [15:0]             r_cnt;
    logic                    r_done;

    logic                    w_ack_s;
    logic                    w_start_edge;
    logic                    w_last;
    logic                    w_busy;
    logic                    w_launch;
    logic                    w_msg_ack;
    logic                    w_req_nxt;

    logic [ASZ-1:0]          w_dst_nxt;
    logic [DSZ-1:0]          w_dat_nxt;
    logic [15:0]             w_cnt_nxt;
    logic                    w_done_nxt;
    logic [NS_FOLD_IN_W-1:0] w_fold_in;
    logic [RSZ-1:0]          w_red_nxt;
    logic [RSZ-1:0]          w_red_rst;

    // ack may come from another clock domain; the FSM only ever looks at w_ack_s.
    ns_sync2 u_ack_sync (
        .i_clk   (i_clk),
        .i_rst_n (reset),
        .i_d     (snd0.ack),
        .o_q     (w_ack_s)
    );

    assign w_start_edge = i_start & ~r_start_q;
    assign w_last       = ((r_cnt + 16'd1) == 16'(NUM_MSGS));

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_edge) w_state_nxt = ST_SETUP;
            end
            // A still-high ack means the receiver has not finished the previous
            // handshake; raising req now would be taken as a duplicate.
            ST_SETUP: begin
                if (!w_ack_s) w_state_nxt = ST_REQ_HI;
            end
            ST_REQ_HI: begin
                if (w_ack_s) w_state_nxt = ST_REQ_LO;
            end
            ST_REQ_LO: begin
                if (!w_ack_s) w_state_nxt = w_last ? ST_DONE : ST_SETUP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        w_busy    = 1'b0;
        w_launch  = 1'b0;
        w_msg_ack = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: w_launch = w_start_edge;
            ST_SETUP, ST_REQ_HI: w_busy = 1'b1;
            ST_REQ_LO: begin
                w_busy    = 1'b1;
                w_msg_ack = ~w_ack_s;
            end
            default: w_busy = 1'b0;
        endcase
        // req comes from a flop so the link never sees decode glitches.
        w_req_nxt = (w_state_nxt == ST_REQ_HI);
    end

    // ---------------- message fields and counters ----------------
    always_comb begin
        w_dst_nxt  = r_dst;
        w_dat_nxt  = r_dat;
        w_cnt_nxt  = r_cnt;
        w_done_nxt = r_done;
        if (w_launch) begin
            w_dst_nxt  = ASZ'(MIN_ADDR);
            w_dat_nxt  = '0;
            w_cnt_nxt  = '0;
            w_done_nxt = 1'b0;
        end else if (w_msg_ack) begin
            w_cnt_nxt = r_cnt + 16'd1;
            if (w_last) begin
                w_done_nxt = 1'b1;
            end else begin
                w_dst_nxt = (r_dst == ASZ'(MAX_ADDR)) ? ASZ'(MIN_ADDR) : r_dst + ASZ'(1);
                w_dat_nxt = r_dat + DSZ'(1);
            end
        end
        w_fold_in = NS_FOLD_IN_W'({ASZ'(REF_ADDR), w_dst_nxt, w_dat_nxt});
    end

    // Redundancy is computed from the next field values so it is registered
    // together with them and stays aligned for the whole message.
    for (genvar j = 0; j < RSZ; j++) begin : g_fold
        assign w_red_nxt[j] = ns_fold_bit(w_fold_in, RSZ, j);
        assign w_red_rst[j] = ns_fold_bit(RST_FOLD_IN, RSZ, j);
    end

    // Fields only change on launch or after the previous message is fully
    // acknowledged, so they are stable from SETUP through the end of REQ_LO.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_start_q <= 1'b0;
            r_req     <= 1'b0;
            r_src     <= ASZ'(REF_ADDR);
            r_dst     <= ASZ'(MIN_ADDR);
            r_dat     <= '0;
            r_red     <= w_red_rst;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_start_q <= i_start;
            r_req     <= w_req_nxt;
            r_src     <= ASZ'(REF_ADDR);
            r_dst     <= w_dst_nxt;
            r_dat     <= w_dat_nxt;
            r_red     <= w_red_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign snd0.req = r_req;
    assign snd0.src = r_src;
    assign snd0.dst = r_dst;
    assign snd0.dat = r_dat;
    assign snd0.red = r_red;
    assign o_busy   = w_busy;
    assign o_done   = r_done;
    assign o_cnt    = r_cnt;

endmodule

// File: tb/tb_ns_seq_src.sv
// Purpose : self-checking bench for ns_seq_src with two differently parameterised instances.
// Latency : n/a.
// Backpr. : bench responders: instance a acks combinationally or one cycle late, b one cycle late.
`timescale 1ns/1ps
module tb_ns_seq_src;
    import ns_seq_src_pkg::*;

    localparam int A_ASZ = 6, A_DSZ = 8, A_RSZ = 4, A_MIN = 0,  A_MAX = 55, A_REF = 23, A_NUM = 3;
    localparam int B_ASZ = 6, B_DSZ = 4, B_RSZ = 3, B_MIN = 54, B_MAX = 55, B_REF = 23, B_NUM = 18;
    localparam int P_ASZ [2] = '{A_ASZ, B_ASZ};
    localparam int P_DSZ [2] = '{A_DSZ, B_DSZ};
    localparam int P_RSZ [2] = '{A_RSZ, B_RSZ};
    localparam int P_MIN [2] = '{A_MIN, B_MIN};
    localparam int P_MAX [2] = '{A_MAX, B_MAX};
    localparam int P_REF [2] = '{A_REF, B_REF};
    localparam int P_NUM [2] = '{A_NUM, B_NUM};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [15:0] cnt_a, cnt_b;
    logic        dly0_a, hold_a;
    logic        ackq_a = 1'b0;
    logic        ackq_b = 1'b0;

    ns_seq_src_if #(.ASZ(A_ASZ), .DSZ(A_DSZ), .RSZ(A_RSZ)) lnk_a ();
    ns_seq_src_if #(.ASZ(B_ASZ), .DSZ(B_DSZ), .RSZ(B_RSZ)) lnk_b ();

    ns_seq_src #(.ASZ(A_ASZ), .DSZ(A_DSZ), .RSZ(A_RSZ), .MIN_ADDR(A_MIN),
                 .MAX_ADDR(A_MAX), .REF_ADDR(A_REF), .NUM_MSGS(A_NUM)) u_a (
        .i_clk(clk), .reset(rst_n), .i_start(start_a), .snd0(lnk_a),
        .o_busy(busy_a), .o_done(done_a), .o_cnt(cnt_a));

    ns_seq_src #(.ASZ(B_ASZ), .DSZ(B_DSZ), .RSZ(B_RSZ), .MIN_ADDR(B_MIN),
                 .MAX_ADDR(B_MAX), .REF_ADDR(B_REF), .NUM_MSGS(B_NUM)) u_b (
        .i_clk(clk), .reset(rst_n), .i_start(start_b), .snd0(lnk_b),
        .o_busy(busy_b), .o_done(done_b), .o_cnt(cnt_b));

    always #5 clk = ~clk;

    // Receivers: ack follows req (combinationally or one cycle late); hold forces ack high.
    always @(posedge clk) begin
        ackq_a <= lnk_a.req;
        ackq_b <= lnk_b.req;
    end
    assign lnk_a.ack = hold_a | (dly0_a ? lnk_a.req : ackq_a);
    assign lnk_b.ack = ackq_b;

    int errors = 0;
    int checks = 0;

    // Transaction-level model: messages fully handshaken on the link per instance.
    int   mk [2];
    logic mseen [2];
    logic mprev_req [2];
    logic mprev_ack [2];
    int   a_dst [3];
    int   b_dst [5];
    int   b_dat16;

    task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_dst(input int id, input int k);
        return P_MIN[id] + (k % (P_MAX[id] - P_MIN[id] + 1));
    endfunction

    function automatic int exp_dat(input int id, input int k);
        return k % (1 << P_DSZ[id]);
    endfunction

    // Parity of the concatenation bits at positions i with i mod rsz == bit.
    function automatic int fold_m(input int id, input int src, input int dst, input int dat);
        longint v;
        int     r;
        v = (longint'(src) << (P_ASZ[id] + P_DSZ[id])) | (longint'(dst) << P_DSZ[id]) | longint'(dat);
        r = 0;
        for (int i = 0; i < 2 * P_ASZ[id] + P_DSZ[id]; i++) begin
            if (((v >> i) & 64'd1) != 0) r = r ^ (1 << (i % P_RSZ[id]));
        end
        return r;
    endfunction

    task automatic cmp(input int id, input logic req, input logic ack, input int src, input int dst,
                       input int dat, input int red, input logic busy, input logic done, input int cnt);
        string p;
        p = (id == 0) ? "a" : "b";
        ck($sformatf("%s_cnt_track", p), (cnt == mk[id]) || (cnt + 1 == mk[id]), 1);
        if (req) begin
            ck($sformatf("%s_dst_k%0d", p, mk[id]), dst, exp_dst(id, mk[id]));
            ck($sformatf("%s_dat_k%0d", p, mk[id]), dat, exp_dat(id, mk[id]));
            ck($sformatf("%s_src", p), src, P_REF[id]);
            ck($sformatf("%s_red_k%0d", p, mk[id]), red, fold_m(id, P_REF[id], exp_dst(id, mk[id]), exp_dat(id, mk[id])));
            ck($sformatf("%s_cnt_at_req", p), cnt, mk[id]);
            ck($sformatf("%s_busy_at_req", p), busy, 1);
            ck($sformatf("%s_done_at_req", p), done, 0);
            if (!mprev_req[id]) begin
                ck($sformatf("%s_ack_low_before_req", p), mprev_ack[id], 0);
                if (id == 0 && mk[id] < 3) a_dst[mk[id]] = dst;
                if (id == 1 && mk[id] < 5) b_dst[mk[id]] = dst;
                if (id == 1 && mk[id] == 16) b_dat16 = dat;
            end
            mseen[id] = 1'b1;
        end
        if (done) begin
            ck($sformatf("%s_done_cnt", p), cnt, P_NUM[id]);
            ck($sformatf("%s_done_busy", p), busy, 0);
            ck($sformatf("%s_done_model", p), mk[id], P_NUM[id]);
        end
        if (mprev_ack[id] && !ack && mseen[id]) begin
            mk[id]++;
            mseen[id] = 1'b0;
        end
        mprev_req[id] = req;
        mprev_ack[id] = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cmp(0, lnk_a.req, lnk_a.ack, int'(lnk_a.src), int'(lnk_a.dst), int'(lnk_a.dat),
            int'(lnk_a.red), busy_a, done_a, int'(cnt_a));
        cmp(1, lnk_b.req, lnk_b.ack, int'(lnk_b.src), int'(lnk_b.dst), int'(lnk_b.dat),
            int'(lnk_b.red), busy_b, done_b, int'(cnt_b));
    endtask

    task automatic wait_done(input int id, input int budget);
        int n;
        n = 0;
        while (((id == 0) ? done_a : done_b) !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        ck((id == 0) ? "a_done_reached" : "b_done_reached", (id == 0) ? done_a : done_b, 1);
    endtask

    task automatic launch_a();
        start_a = 1'b0;
        tick();
        start_a = 1'b1;
        mk[0] = 0;
        mseen[0] = 1'b0;
        tick();
        ck("a_launch_done_clr", done_a, 0);
        ck("a_launch_busy", busy_a, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; dly0_a = 1'b1; hold_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mk[i] = 0; mseen[i] = 1'b0; mprev_req[i] = 1'b0; mprev_ack[i] = 1'b0;
        end
        b_dat16 = -1;
        repeat (3) tick();
        // Reset values, with fold results worked by hand.
        ck("a_rst_req", lnk_a.req, 0);
        ck("a_rst_src", lnk_a.src, 23);
        ck("a_rst_dst", lnk_a.dst, 0);
        ck("a_rst_dat", lnk_a.dat, 0);
        ck("a_rst_red", lnk_a.red, 9);
        ck("a_rst_busy", busy_a, 0);
        ck("a_rst_done", done_a, 0);
        ck("a_rst_cnt", cnt_a, 0);
        ck("b_rst_dst", lnk_b.dst, 54);
        ck("b_rst_red", lnk_b.red, 3);
        rst_n = 1'b1;
        tick();
        tick();

        // Run 1: a with same-cycle ack (timing), b with delayed ack.
        start_a = 1'b1;
        start_b = 1'b1;
        n = 0;
        while (lnk_a.req !== 1'b1 && n < 10) begin tick(); n++; end
        ck("a_start_to_req", n, 2);
        n = 0;
        while (lnk_a.req === 1'b1 && n < 10) begin tick(); n++; end
        ck("a_req_high_cycles", n, 3);
        while (lnk_a.req !== 1'b1 && n < 20) begin tick(); n++; end
        ck("a_handshake_period", n, 7);
        start_b = 1'b0;
        wait_done(0, 100);
        wait_done(1, 400);
        ck("a_run1_cnt", cnt_a, 3);
        ck("b_run1_cnt", cnt_b, 18);
        ck("a_dst0", a_dst[0], 0);
        ck("a_dst1", a_dst[1], 1);
        ck("a_dst2", a_dst[2], 2);
        ck("b_dst0", b_dst[0], 54);
        ck("b_dst1", b_dst[1], 55);
        ck("b_dst2", b_dst[2], 54);
        ck("b_dst3", b_dst[3], 55);
        ck("b_dst4", b_dst[4], 54);
        ck("b_dat_wrap_msg17", b_dat16, 0);

        // Run 2: delayed ack, start pulse mid-run is ignored.
        dly0_a = 1'b0;
        launch_a();
        n = 0;
        while (!(mk[0] == 1 && lnk_a.req === 1'b1) && n < 100) begin tick(); n++; end
        ck("a_reach_msg1", mk[0], 1);
        start_a = 1'b0;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done(0, 100);
        ck("a_run2_cnt", cnt_a, 3);

        // Run 3: ack held high at start keeps req low in SETUP.
        hold_a = 1'b1;
        launch_a();
        for (int i = 0; i < 8; i++) begin
            tick();
            ck("a_hold_req_low", lnk_a.req, 0);
            ck("a_hold_busy", busy_a, 1);
        end
        hold_a = 1'b0;
        wait_done(0, 100);
        ck("a_run3_cnt", cnt_a, 3);

        // Run 4: reset with req high after two messages.
        launch_a();
        n = 0;
        while (!(mk[0] == 2 && lnk_a.req === 1'b1) && n < 100) begin tick(); n++; end
        ck("a_reach_msg2", lnk_a.req, 1);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin mk[i] = 0; mseen[i] = 1'b0; end
        #1;
        ck("a_mid_rst_req", lnk_a.req, 0);
        ck("a_mid_rst_cnt", cnt_a, 0);
        ck("a_mid_rst_busy", busy_a, 0);
        ck("a_mid_rst_done", done_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        launch_a();
        n = 0;
        while (lnk_a.req !== 1'b1 && n < 10) begin tick(); n++; end
        ck("a_restart_dst", lnk_a.dst, 0);
        ck("a_restart_dat", lnk_a.dat, 0);
        wait_done(0, 100);
        ck("a_run4_cnt", cnt_a, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
